// File: rtl/mips_defines.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_defines
// Shared MIPS constants: reset vector, fetch FSM encoding, opcode values and
// instruction field positions.
// Revision: 1.0
// ---------------------------------------------------------------------------
package mips_defines;

  // Default first fetch address after reset
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Instruction fetch FSM encoding
  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_WAIT = 2'd1,
    IF_FULL = 2'd2
  } if_state_t;

  // Primary opcode values (instr[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_BEQ     = 6'h04;

  // Instruction field positions
  localparam int INDEX_MSB = 25;  // J-type instr_index is [25:0]
  localparam int IMM_MSB   = 15;  // I-type immediate is [15:0]

endpackage
`default_nettype wire

// File: rtl/pc_target.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_target
// Combinational redirect target: JR > J > branch priority.
// Revision: 1.0
// ---------------------------------------------------------------------------
module pc_target
  import mips_defines::*;
(
  input  logic [31:0]        pc_id,
  input  logic [INDEX_MSB:0] instr_field,
  input  logic [31:0]        jr_pc,
  input  logic               jump_reg,
  input  logic               jump_target,
  output logic [31:0]        target
);

  logic [31:0] pc_plus4;
  logic [31:0] j_tgt;
  logic [31:0] br_off;
  logic [31:0] br_tgt;

  // Select the redirect target; branch is the fall-back when neither J nor JR
  always_comb begin
    pc_plus4 = pc_id + 32'd4;
    j_tgt    = {pc_plus4[31:28], instr_field[INDEX_MSB:0], 2'b00};
    br_off   = {{14{instr_field[IMM_MSB]}}, instr_field[IMM_MSB:0], 2'b00};
    br_tgt   = pc_plus4 + br_off;
    if (jump_reg) begin
      target = jr_pc;
    end else if (jump_target) begin
      target = j_tgt;
    end else begin
      target = br_tgt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instruction_fetch
// Single-outstanding instruction fetch with a one-entry skid buffer, IF/ID
// register and delay-slot preserving redirect handling.
// Revision: 1.0
// ---------------------------------------------------------------------------
module instruction_fetch
  import mips_defines::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        jump_branch,
  input  logic        jump_target,
  input  logic        jump_reg,
  input  logic [31:0] jr_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_id,
  output logic [31:0] instr_id,
  output logic        valid_id
);

  if_state_t   state;
  logic [31:0] pc_f;        // address of the next request
  logic [31:0] req_pc;      // address of the granted, in-flight request
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;
  logic        pend_valid;  // redirect waiting for the delay-slot grant
  logic [31:0] pend_tgt;

  logic        grant;
  logic        advance;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_id_p4;

  assign imem_req  = (state == IF_IDLE);
  assign imem_addr = pc_f;
  assign grant     = imem_req & imem_gnt;
  assign advance   = ~stall | ~valid_id;
  assign redirect  = valid_id & advance & (jump_reg | jump_target | jump_branch);
  assign pc_id_p4  = pc_id + 32'd4;

  pc_target u_pc_target (
    .pc_id       (pc_id),
    .instr_field (instr_id[INDEX_MSB:0]),
    .jr_pc       (jr_pc),
    .jump_reg    (jump_reg),
    .jump_target (jump_target),
    .target      (target)
  );

  // Fetch FSM, skid buffer and IF/ID register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IF_IDLE;
      req_pc     <= 32'd0;
      skid_pc    <= 32'd0;
      skid_instr <= 32'd0;
      pc_id      <= 32'd0;
      instr_id   <= 32'd0;
      valid_id   <= 1'b0;
    end else begin
      case (state)
        IF_IDLE: begin
          if (grant) begin
            req_pc <= pc_f;
            state  <= IF_WAIT;
          end
        end
        IF_WAIT: begin
          if (imem_rvalid && !advance) begin
            skid_pc    <= req_pc;
            skid_instr <= imem_rdata;
            state      <= IF_FULL;
          end else if (imem_rvalid) begin
            state <= IF_IDLE;
          end
        end
        IF_FULL: begin
          if (advance) begin
            state <= IF_IDLE;
          end
        end
        default: state <= IF_IDLE;
      endcase

      if (advance) begin
        if (state == IF_FULL) begin
          valid_id <= 1'b1;
          pc_id    <= skid_pc;
          instr_id <= skid_instr;
        end else if (state == IF_WAIT && imem_rvalid) begin
          valid_id <= 1'b1;
          pc_id    <= req_pc;
          instr_id <= imem_rdata;
        end else begin
          valid_id <= 1'b0;
        end
      end
    end
  end

  // Next fetch address: the delay slot at pc_id+4 is always fetched before
  // the redirect target. If it is not yet requested and not being granted
  // now, the target waits in the pending register for that grant; otherwise
  // (delay slot already issued, or issuing this cycle) the target is taken
  // immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f       <= RESET_PC;
      pend_valid <= 1'b0;
      pend_tgt   <= 32'd0;
    end else if (redirect && (pc_f == pc_id_p4) && !grant) begin
      pend_valid <= 1'b1;
      pend_tgt   <= target;
    end else if (redirect) begin
      pc_f       <= target;
      pend_valid <= 1'b0;
    end else if (grant && pend_valid) begin
      pc_f       <= pend_tgt;
      pend_valid <= 1'b0;
    end else if (grant) begin
      pc_f <= pc_f + 32'd4;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_instruction_fetch
// Self-checking bench: memory model with random grant/latency, program-order
// reference of the instruction stream reaching ID, directed scenarios and a
// long randomized run.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_instruction_fetch;
  import mips_defines::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        jump_branch;
  logic        jump_target;
  logic        jump_reg;
  logic [31:0] jr_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_id;
  logic [31:0] instr_id;
  logic        valid_id;

  instruction_fetch #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .jump_branch (jump_branch),
    .jump_target (jump_target),
    .jump_reg    (jump_reg),
    .jr_pc       (jr_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc_id       (pc_id),
    .instr_id    (instr_id),
    .valid_id    (valid_id)
  );

  always #5 clk = ~clk;

  // counters
  int n_chk  = 0;
  int n_pass = 0;
  int n_entries = 0;

  // program image overrides, directed behaviour per PC
  logic [31:0] prog      [logic [31:0]];
  int          dir_kind  [logic [31:0]];   // bit0 branch, bit1 J, bit2 JR
  int          dir_stall [logic [31:0]];
  logic [31:0] dir_jr    [logic [31:0]];

  // stimulus configuration
  int gnt_pct, stall_pct, jump_pct, lat_min, lat_max;
  bit rand_mode;

  // memory model
  bit          outstanding;
  logic [31:0] out_addr;
  int          out_lat;
  int          buffered;     // delivered responses not yet in ID
  logic [31:0] gq[$];        // granted addresses in order

  // values driven / observed at the previous falling edge
  bit          prev_req, prev_gnt, prev_rvalid, prev_adv;
  logic [31:0] prev_addr;

  // program-order reference of the ID stream
  logic [31:0] next_pc;
  bit          pend_v;
  logic [31:0] pend_tgt;
  bit          in_slot;
  logic [31:0] cur_pc, cur_instr, cur_jr;
  logic [2:0]  cur_kind;
  int          stall_left;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    if (prog.exists(a)) return prog[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic reset_model();
    outstanding = 0; out_lat = 0; buffered = 0;
    prev_req = 0; prev_gnt = 0; prev_rvalid = 0; prev_adv = 0; prev_addr = 0;
    next_pc = RST_PC; pend_v = 0; pend_tgt = 0; in_slot = 0;
    cur_pc = 0; cur_instr = 0; cur_jr = 0; cur_kind = 0; stall_left = 0;
  endtask

  // A new instruction has entered ID: check it and decide its decode flags
  task automatic take_entry();
    logic [31:0] p;
    logic [31:0] r;
    int imm;
    p = next_pc;
    check("pc_id", pc_id, p);
    check("instr_id", instr_id, instr_of(p));
    n_entries++;
    cur_pc    = p;
    cur_instr = instr_of(p);
    next_pc   = pend_v ? pend_tgt : p + 32'd4;
    in_slot   = pend_v;
    pend_v    = 0;
    if (dir_kind.exists(p)) cur_kind = 3'(dir_kind[p]);
    else if (!in_slot && rand_mode && ($urandom_range(0, 99) < jump_pct))
      cur_kind = 3'($urandom_range(1, 7));
    else cur_kind = 3'd0;
    r = $urandom();
    cur_jr = dir_jr.exists(p) ? dir_jr[p] : {r[31:2], 2'b00};
    stall_left = dir_stall.exists(p) ? dir_stall[p] : 0;
    if (cur_kind != 3'd0) begin
      pend_v = 1;
      if (cur_kind[2]) pend_tgt = cur_jr;
      else if (cur_kind[1])
        pend_tgt = ((p + 32'd4) & 32'hF000_0000) | ((cur_instr & 32'h03FF_FFFF) << 2);
      else begin
        imm = int'($signed(cur_instr[15:0]));
        pend_tgt = p + 32'd4 + 32'(imm * 4);
      end
    end
  endtask

  // Account for what happened at the rising edge just passed and check it
  task automatic resolve();
    if (prev_rvalid) begin
      outstanding = 0;
      buffered++;
    end
    if (prev_req && prev_gnt) begin
      outstanding = 1;
      out_addr = prev_addr;
      out_lat = $urandom_range(lat_min, lat_max);
      gq.push_back(prev_addr);
    end
    if (prev_adv) begin
      check("valid_id", {31'd0, valid_id}, {31'd0, buffered > 0});
      if (buffered > 0) begin
        buffered--;
        take_entry();
      end else begin
        cur_kind = 3'd0;
      end
    end else begin
      check("hold_valid", {31'd0, valid_id}, 32'd1);
      check("hold_pc", pc_id, cur_pc);
      check("hold_instr", instr_id, cur_instr);
    end
    check("imem_req", {31'd0, imem_req}, {31'd0, !(outstanding || buffered > 0)});
    if (prev_req && !prev_gnt && imem_req)
      check("addr_stable", imem_addr, prev_addr);
  endtask

  // Drive inputs for the coming rising edge
  task automatic drive();
    bit rv;
    rv = 0;
    if (outstanding) begin
      if (out_lat > 0) out_lat--;
      if (out_lat == 0) rv = 1;
    end
    imem_rvalid = rv;
    imem_rdata  = rv ? instr_of(out_addr) : $urandom();
    imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
    jump_branch = valid_id && cur_kind[0];
    jump_target = valid_id && cur_kind[1];
    jump_reg    = valid_id && cur_kind[2];
    jr_pc       = cur_jr;
    if (valid_id && stall_left > 0) begin
      stall = 1'b1;
      stall_left--;
    end else begin
      stall = ($urandom_range(0, 99) < stall_pct);
    end
    prev_req    = imem_req;
    prev_gnt    = imem_gnt;
    prev_addr   = imem_addr;
    prev_rvalid = rv;
    prev_adv    = !stall || !valid_id;
  endtask

  task automatic cycle();
    @(negedge clk);
    resolve();
    drive();
  endtask

  logic [31:0] exp_q[$];

  initial begin
    rst_n = 1'b0; stall = 0; jump_branch = 0; jump_target = 0; jump_reg = 0;
    jr_pc = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    reset_model();

    // reset state
    repeat (3) @(negedge clk);
    check("rst_valid_id", {31'd0, valid_id}, 32'd0);
    check("rst_pc_id", pc_id, 32'd0);
    check("rst_instr_id", instr_id, 32'd0);
    check("rst_imem_addr", imem_addr, RST_PC);
    rst_n = 1'b1;
    check("req_after_reset", {31'd0, imem_req}, 32'd1);

    // directed program: sequential fetch, stall while FULL, BEQ, JR, J with
    // delay slot in flight, and JR+J together
    gnt_pct = 100; stall_pct = 0; jump_pct = 0; lat_min = 1; lat_max = 1;
    rand_mode = 0;
    dir_stall[32'h0000_000C] = 3;
    prog[32'h0000_0020]     = {OP_BEQ, 5'd1, 5'd1, 16'h0004};
    dir_kind[32'h0000_0020] = 1;
    dir_kind[32'h0000_0038] = 4;
    dir_jr[32'h0000_0038]   = 32'h1000_0040;
    prog[32'h1000_0040]      = {OP_J, 26'h000_0100};
    dir_kind[32'h1000_0040]  = 2;
    dir_stall[32'h1000_0040] = 1;
    prog[32'h1000_0400]     = {OP_J, 26'h3FF_FFFF};
    dir_kind[32'h1000_0400] = 6;
    dir_jr[32'h1000_0400]   = 32'h0000_0800;
    drive();
    repeat (80) cycle();

    for (int a = 0; a <= 32'h24; a += 4) exp_q.push_back(32'(a));
    exp_q.push_back(32'h0000_0034); exp_q.push_back(32'h0000_0038);
    exp_q.push_back(32'h0000_003C); exp_q.push_back(32'h1000_0040);
    exp_q.push_back(32'h1000_0044); exp_q.push_back(32'h1000_0400);
    exp_q.push_back(32'h1000_0404); exp_q.push_back(32'h0000_0800);
    exp_q.push_back(32'h0000_0804); exp_q.push_back(32'h0000_0808);
    if (gq.size() < exp_q.size()) begin
      check("grant_count", 32'(gq.size()), 32'(exp_q.size()));
    end else begin
      for (int i = 0; i < exp_q.size(); i++) check("fetch_seq", gq[i], exp_q[i]);
    end

    // reset while a response is in flight
    lat_min = 3; lat_max = 3;
    for (int k = 0; k < 20 && !(outstanding && !prev_rvalid); k++) cycle();
    check("reach_wait", {31'd0, outstanding && !prev_rvalid}, 32'd1);
    rst_n = 1'b0; imem_rvalid = 0; imem_gnt = 0; stall = 0;
    jump_branch = 0; jump_target = 0; jump_reg = 0;
    @(negedge clk);
    rst_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    check("req_after_abort", {31'd0, imem_req}, 32'd1);
    check("addr_after_abort", imem_addr, RST_PC);
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("stale_valid_id", {31'd0, valid_id}, 32'd0);
    check("stale_instr_id", instr_id, 32'd0);
    check("stale_imem_addr", imem_addr, RST_PC);

    // randomized run against the program-order reference
    prog.delete(); dir_kind.delete(); dir_stall.delete(); dir_jr.delete();
    gq.delete();
    reset_model();
    n_entries = 0;
    gnt_pct = 70; stall_pct = 30; jump_pct = 25; lat_min = 1; lat_max = 3;
    rand_mode = 1;
    drive();
    repeat (3000) cycle();
    check("progress", {31'd0, n_entries > 300}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have ports clk  in  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have ports rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports stall  in  1  decode hold; IF/ID contents must not change.
REQ-005 SHALL have ports jump_branch, jump_target, jump_reg  in  1 each  taken-branch, J and JR flags from decode for instr_id.
REQ-006 SHALL have ports jr_pc  in  32  forwarded register target for JR.
REQ-007 SHALL have ports imem_req  out  1, imem_addr  out  32, imem_gnt  in  1  request handshake; a transfer occurs when req & gnt.
REQ-008 SHALL have ports imem_rvalid  in  1, imem_rdata  in  32  response, one per granted request, latency of one or more cycles.
REQ-009 SHALL have ports pc_id  out  32, instr_id  out  32, valid_id  out  1  the IF/ID register feeding decode.

Function
REQ-010 SHALL hold at most one granted-but-unanswered request; pc_f is the address of the next request.
REQ-011 SHALL implement FSM IDLE -> WAIT on req&gnt; WAIT -> IDLE on rvalid when IF/ID advances; WAIT -> FULL on rvalid when IF/ID holds; FULL -> IDLE when IF/ID advances.
REQ-012 SHALL assert imem_req only in IDLE, with imem_addr = pc_f held stable until gnt.
REQ-013 SHALL define advance = ~stall | ~valid_id.
REQ-014 SHALL on advance load IF/ID from the skid buffer (FULL), else from rvalid in WAIT, else load valid_id = 0 (bubble).
REQ-015 SHALL give pc_id the address latched at grant time, not pc_f.
REQ-016 SHALL ignore imem_rvalid in IDLE and FULL.
REQ-017 SHALL on grant set pc_f = pc_f + 4 (32-bit wrap), unless REQ-020 applies.
REQ-018 SHALL evaluate redirects only when valid_id & advance, with priority jump_reg > jump_target > jump_branch.
REQ-019 SHALL compute targets: JR = jr_pc; J = {pc_id+4 [31:28], instr_id[25:0], 2'b00}; branch = pc_id + 4 + (sign-extended instr_id[15:0] << 2).
REQ-020 SHALL preserve the delay slot:
  - if pc_f == pc_id+8, set pc_f = target immediately.
  - if pc_f == pc_id+4, latch the target as pending; the grant of pc_id+4 then loads pc_f = pending target and clears pending.
REQ-021 SHALL give a redirect coinciding with a grant precedence over +4 per REQ-020.

Reset
REQ-022 SHALL, on rst_n low, asynchronously force:
  - state IDLE, pc_f = RESET_PC.
  - valid_id = 0, pc_id = 0, instr_id = 0.
  - pending redirect cleared, skid buffer empty.
REQ-023 SHALL treat a reset mid-WAIT as an abort: the in-flight response is discarded.
REQ-024 SHALL drive imem_req = 1 in the first cycle after rst_n deasserts.

Structure
REQ-025 SHALL place the RESET_PC default and the FSM state encoding in the shared mips_defines package.
REQ-026 SHALL use mips_defines opcode constants wherever instr_id is inspected.
REQ-027 SHALL place the target arithmetic of REQ-019 in a combinational sub-module named pc_target.

Verification
REQ-028 SHALL cover sequential fetch: gnt tied 1, rvalid one cycle later, RESET_PC = 0 -> imem_addr 0, 4, 8; pc_id follows 0, 4, 8 with valid_id = 1.
REQ-029 SHALL cover stall while FULL: stall = 1 for 3 cycles while the response for 0x10 arrives -> instr_id unchanged, state FULL, no imem_req; the 0x10 instruction reaches ID the cycle after stall drops.
REQ-030 SHALL cover branch with delay slot not issued: BEQ at 0x20 taken, imm 0x0004, pc_f = 0x24 -> fetch 0x24 then 0x34.
REQ-031 SHALL cover J with delay slot in flight: pc_id = 0x1000_0040, instr_index 0x0000100, pc_f = 0x1000_0048 -> next request 0x1000_0400.
REQ-032 SHALL cover JR and J asserted together: jr_pc = 0x0000_0800 -> target 0x800.
REQ-033 SHALL cover reset in WAIT: rst_n low for 1 cycle, then rvalid with data 0xDEAD_BEEF -> valid_id stays 0, data dropped, next imem_addr = RESET_PC.
